keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it, and emits one 4-bit key code per press.

---
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and key-code output.
// Optional auto-repeat when TYPEMATIC_EN is defined.
module keypad_scanner #(
  parameter int SCAN_TICKS = 50000,
  parameter int DEB_COUNT  = 20,
  parameter int REP_DELAY  = 500,
  parameter int REP_RATE   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(DEB_COUNT + 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    row_s1, row_s2;
  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    col, col_nx;
  logic [1:0]    cand, cand_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] rel, rel_nx;
  logic [3:0]    code_nx;
  logic          valid_nx, held_nx;
  logic [3:0]    rows;
  logic          one_hot;
  logic [1:0]    ridx;
  logic          match, all_high;

`ifdef TYPEMATIC_EN
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep, rep_nx, rep_tgt;
  logic          fast, fast_nx;
  assign rep_tgt = fast ? RW'(REP_RATE) : RW'(REP_DELAY);
`endif

  function automatic logic [3:0] map(input logic [1:0] r,
                                     input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'hE;
      4'h1:    k = 4'hD;
      4'h2:    k = 4'hC;
      4'h3:    k = 4'h5;
      4'h4:    k = 4'hB;
      4'h5:    k = 4'hA;
      4'h6:    k = 4'h9;
      4'h7:    k = 4'h4;
      4'h8:    k = 4'h8;
      4'h9:    k = 4'h7;
      4'hA:    k = 4'h6;
      4'hB:    k = 4'h3;
      4'hC:    k = 4'h1;
      4'hD:    k = 4'hF;
      4'hE:    k = 4'h0;
      default: k = 4'h2;
    endcase
    return k;
  endfunction

  assign col_n = ~(4'b0001 << col);
  assign tick  = (pre == PW'(SCAN_TICKS - 1));

  // two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // free-running prescaler producing the scan tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else if (tick) pre <= '0;
    else pre <= pre + 1'b1;
  end

  // decode synchronized rows; ridx only meaningful when one_hot
  always_comb begin
    rows     = ~row_s2;
    one_hot  = (rows != 4'h0) && ((rows & (rows - 4'h1)) == 4'h0);
    ridx     = {rows[3] | rows[2], rows[3] | rows[1]};
    match    = (row_s2 == ~(4'b0001 << cand));
    all_high = (row_s2 == 4'hF);
  end

  // next-state and output logic
  always_comb begin
    state_nx = state;
    col_nx   = col;
    cand_nx  = cand;
    cnt_nx   = cnt;
    rel_nx   = rel;
    code_nx  = key_code;
    valid_nx = 1'b0;
    held_nx  = key_held;
`ifdef TYPEMATIC_EN
    rep_nx   = rep;
    fast_nx  = fast;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_hot) begin
            cand_nx  = ridx;
            cnt_nx   = CW'(1);
            state_nx = DEBOUNCE;
          end else begin
            col_nx = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state_nx = SCAN;
            col_nx   = col + 2'd1;
            cnt_nx   = '0;
          end else if (cnt == CW'(DEB_COUNT - 1)) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
            rel_nx   = '0;
            valid_nx = 1'b1;
            held_nx  = 1'b1;
            code_nx  = map(cand, col);
`ifdef TYPEMATIC_EN
            rep_nx   = '0;
            fast_nx  = 1'b0;
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (all_high) begin
`ifdef TYPEMATIC_EN
            rep_nx  = '0;
            fast_nx = 1'b0;
`endif
            if (rel == CW'(DEB_COUNT - 1)) begin
              state_nx = SCAN;
              col_nx   = col + 2'd1;
              held_nx  = 1'b0;
              rel_nx   = '0;
            end else begin
              rel_nx = rel + 1'b1;
            end
          end else begin
            rel_nx = '0;
`ifdef TYPEMATIC_EN
            if (!row_s2[cand]) begin
              if (rep + 1'b1 == rep_tgt) begin
                valid_nx = 1'b1;
                rep_nx   = '0;
                fast_nx  = 1'b1;
              end else begin
                rep_nx = rep + 1'b1;
              end
            end
`endif
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      cand      <= 2'd0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      col       <= col_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      rel       <= rel_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

`ifdef TYPEMATIC_EN
  // auto-repeat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep  <= '0;
      fast <= 1'b0;
    end else begin
      rep  <= rep_nx;
      fast <= fast_nx;
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus
// scoreboard of expected key codes checked on each strobe.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] keymat [4];
  logic [3:0] exp_q [$];
  int vectors = 0;
  int errors  = 0;

  keypad_scanner #(
    .SCAN_TICKS(4),
    .DEB_COUNT (3),
    .REP_DELAY (8),
    .REP_RATE  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a row reads low when a closed key sits on the driven column
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(keymat[r] & ~col_n);
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // monitor: every strobe must match the next expected code
  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL strobe: got unexpected code %b expected none",
                 key_code);
      end else begin
        chk("strobe_code", key_code, exp_q.pop_front());
        chk("strobe_held", {3'b0, key_held}, 4'h1);
      end
    end
  end

  task automatic press(input int r, input int c);
    keymat[r][c] = 1'b1;
  endtask

  task automatic open_all();
    for (int r = 0; r < 4; r++) keymat[r] = 4'h0;
  endtask

  task automatic wait_held(input logic v, input int budget);
    int n = 0;
    while (key_held !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("held_wait", {3'b0, key_held}, {3'b0, v});
  endtask

  task automatic wait_col(input logic [3:0] v);
    int n = 0;
    while (col_n == v && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (col_n != v && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("col_align", col_n, v);
  endtask

  task automatic tap(input int r, input int c, input logic [3:0] code);
    exp_q.push_back(code);
    press(r, c);
    wait_held(1'b1, 60);
    repeat (8) @(negedge clk);
    open_all();
    wait_held(1'b0, 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    open_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("first_tick_col", col_n, 4'b1101);

    // reset mid-scan
    rst_n = 1'b0;
    #1;
    chk("rst_col", col_n, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", {3'b0, key_valid}, 4'h0);
    chk("rst_held", {3'b0, key_held}, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // key '5' closed 10 ticks then opened
    exp_q.push_back(4'b1010);
    press(1, 1);
    repeat (40) @(negedge clk);
    chk("k5_held", {3'b0, key_held}, 4'h1);
    chk("k5_code", key_code, 4'b1010);
    open_all();
    repeat (8) @(negedge clk);
    chk("k5_held_2t", {3'b0, key_held}, 4'h1);
    repeat (11) @(negedge clk);
    chk("k5_released", {3'b0, key_held}, 4'h0);

    // key '8' bounces for two ticks on column 1
    wait_col(4'b1101);
    press(2, 1);
    repeat (8) @(negedge clk);
    open_all();
    repeat (4) @(negedge clk);
    chk("bounce_col", col_n, 4'b1011);
    chk("bounce_held", {3'b0, key_held}, 4'h0);

    // bottom row keys
    tap(3, 0, 4'b0001);
    tap(3, 2, 4'b0000);
    tap(3, 3, 4'b0010);

    // two rows on column 2: ghost, keep rotating
    press(0, 2);
    press(2, 2);
    wait_col(4'b1110);
    repeat (4) @(negedge clk);
    chk("ghost_c1", col_n, 4'b1101);
    repeat (4) @(negedge clk);
    chk("ghost_c2", col_n, 4'b1011);
    repeat (4) @(negedge clk);
    chk("ghost_c3", col_n, 4'b0111);
    repeat (4) @(negedge clk);
    chk("ghost_c0", col_n, 4'b1110);
    chk("ghost_held", {3'b0, key_held}, 4'h0);
    open_all();
    repeat (8) @(negedge clk);

    // hold '7' for 26 ticks after accept
`ifdef TYPEMATIC_EN
    repeat (6) exp_q.push_back(4'b1000);
`else
    exp_q.push_back(4'b1000);
`endif
    press(2, 0);
    wait_held(1'b1, 60);
    repeat (104) @(negedge clk);
    chk("k7_code", key_code, 4'b1000);
    open_all();
    wait_held(1'b0, 60);

    // reset while a key is held
    exp_q.push_back(4'b1110);
    press(0, 0);
    wait_held(1'b1, 60);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_col", col_n, 4'b1110);
    chk("rst2_code", key_code, 4'h0);
    chk("rst2_valid", {3'b0, key_valid}, 4'h0);
    chk("rst2_held", {3'b0, key_held}, 4'h0);
    open_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_held", {3'b0, key_held}, 4'h0);
    chk("queue_left", 4'(exp_q.size()), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
